// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch queue.
//   DefaultPcW / DefaultIrW : default PC and instruction widths
//   fetch_entry_t           : one {pc, ir} pair at the default widths
//   ptr_add                 : circular pointer advance for any (non power-of-two) depth
package fetch_pkg;

  localparam int unsigned DefaultPcW = 32;
  localparam int unsigned DefaultIrW = 32;

  typedef struct packed {
    logic [DefaultPcW-1:0] pc;
    logic [DefaultIrW-1:0] ir;
  } fetch_entry_t;

  // Compare-and-subtract wrap; callers guarantee inc <= depth so one subtract suffices.
  function automatic int unsigned ptr_add(int unsigned ptr, int unsigned inc,
                                          int unsigned depth);
    int unsigned sum;
    sum = ptr + inc;
    if (sum >= depth) sum = sum - depth;
    return sum;
  endfunction

endpackage

// File: rtl/fetch_queue_sva.sv
// Protocol and invariant checks for fetch_queue, attached with bind.
//   in_valid must be a prefix mask, out_take must not exceed the presented
//   entries (ignored on flush), occupancy never exceeds DEPTH.
module fetch_queue_sva #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IN_W  = 2,
  parameter int unsigned OUT_W = 2
) (
  input logic                         clk,
  input logic                         rstn,
  input logic [IN_W-1:0]              in_valid,
  input logic                         flush,
  input logic [$clog2(OUT_W+1)-1:0]   out_take,
  input logic [OUT_W-1:0]             out_valid,
  input logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  a_in_prefix: assert property (@(posedge clk) disable iff (!rstn)
    ((in_valid & (in_valid + IN_W'(1))) == '0));

  a_take_le_avail: assert property (@(posedge clk) disable iff (!rstn)
    !flush |-> (32'(out_take) <= 32'($countones(out_valid))));

  a_count_le_depth: assert property (@(posedge clk) disable iff (!rstn)
    count <= CW'(DEPTH));

endmodule

bind fetch_queue fetch_queue_sva #(
  .DEPTH (DEPTH),
  .IN_W  (IN_W),
  .OUT_W (OUT_W)
) u_fetch_queue_sva (
  .clk       (clk),
  .rstn      (rstn),
  .in_valid  (in_valid),
  .flush     (flush),
  .out_take  (out_take),
  .out_valid (out_valid),
  .count     (count)
);

// File: rtl/fq_popcount.sv
// Population count of a small lane mask.
//   mask_i : lane mask (W bits)
//   cnt_o  : number of set bits
module fq_popcount #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0]             mask_i,
  output logic [$clog2(W+1)-1:0]   cnt_o
);

  localparam int unsigned CntW = $clog2(W + 1);

  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < W; i++) begin
      cnt_o = cnt_o + CntW'(mask_i[i]);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch (IF2) and decode (ID1).
//   clk, rstn          : clock, asynchronous active-low reset
//   in_valid/pc/ir     : up to IN_W prefix-contiguous {pc, ir} pairs per cycle
//   stall_icache       : masks the whole enqueue group
//   flush              : empties the queue; overrides all other inputs
//   out_take           : number of presented entries consumed this cycle
//   out_valid/pc/ir    : oldest OUT_W entries, first-word-fall-through
//   almost_full        : registered, count >= DEPTH-AF_MARGIN
//   count              : occupancy
//   overflow_err       : sticky, set when an enqueue group is dropped
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IN_W      = 2,
  parameter int unsigned OUT_W     = 2,
  parameter int unsigned PC_W      = DefaultPcW,
  parameter int unsigned IR_W      = DefaultIrW,
  parameter int unsigned AF_MARGIN = 6
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [IN_W-1:0]              in_valid,
  input  logic [IN_W*PC_W-1:0]         in_pc,
  input  logic [IN_W*IR_W-1:0]         in_ir,
  input  logic                         stall_icache,
  input  logic                         flush,
  input  logic [$clog2(OUT_W+1)-1:0]   out_take,
  output logic [OUT_W-1:0]             out_valid,
  output logic [OUT_W*PC_W-1:0]        out_pc,
  output logic [OUT_W*IR_W-1:0]        out_ir,
  output logic                         almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow_err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(IN_W + 1);
  localparam int unsigned OW = $clog2(OUT_W + 1);

  logic [PC_W-1:0] mem_pc_q [DEPTH];
  logic [IR_W-1:0] mem_ir_q [DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          af_q, af_d, ovf_q, ovf_d;

  logic [IN_W-1:0] in_mask;
  logic [IW-1:0]   n_in;
  logic [OW-1:0]   n_avail, n_out;
  logic [CW:0]     post_occ;
  logic            space_ok, do_write;
  logic [PW-1:0]   rd_slot [OUT_W];
  logic [PW-1:0]   wr_slot [IN_W];

  assign in_mask = in_valid & ~{IN_W{stall_icache}};

  fq_popcount #(.W(IN_W)) u_pop_in (
    .mask_i (in_mask),
    .cnt_o  (n_in)
  );

  // Presented entries, read straight from storage (no bypass).
  always_comb begin
    for (int unsigned i = 0; i < OUT_W; i++) begin
      rd_slot[i]                 = PW'(ptr_add(32'(tail_q), i, DEPTH));
      out_valid[i]               = 32'(count_q) > i;
      out_pc[i*PC_W +: PC_W]     = mem_pc_q[rd_slot[i]];
      out_ir[i*IR_W +: IR_W]     = mem_ir_q[rd_slot[i]];
    end
  end

  fq_popcount #(.W(OUT_W)) u_pop_out (
    .mask_i (out_valid),
    .cnt_o  (n_avail)
  );

  assign n_out    = (out_take > n_avail) ? n_avail : out_take;
  // Space is judged after this cycle's dequeue, so full + take + enqueue is legal.
  assign post_occ = {1'b0, count_q} - (CW+1)'(n_out) + (CW+1)'(n_in);
  assign space_ok = post_occ <= (CW+1)'(DEPTH);
  assign do_write = !flush && space_ok;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    af_d    = af_q;
    ovf_d   = ovf_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      af_d    = 1'b0;
    end else begin
      tail_d = PW'(ptr_add(32'(tail_q), 32'(n_out), DEPTH));
      if (space_ok) begin
        head_d  = PW'(ptr_add(32'(head_q), 32'(n_in), DEPTH));
        count_d = post_occ[CW-1:0];
      end else begin
        // Whole group dropped; the dequeue still proceeds.
        count_d = count_q - CW'(n_out);
        ovf_d   = 1'b1;
      end
      af_d = count_d >= CW'(DEPTH - AF_MARGIN);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < IN_W; i++) begin
      wr_slot[i] = PW'(ptr_add(32'(head_q), i, DEPTH));
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (do_write && (i < 32'(n_in))) begin
        mem_pc_q[wr_slot[i]] <= in_pc[i*PC_W +: PC_W];
        mem_ir_q[wr_slot[i]] <= in_ir[i*IR_W +: IR_W];
      end
    end
  end

  assign almost_full  = af_q;
  assign count        = count_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFM   = 6;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  in_valid;
  logic [63:0] in_pc, in_ir;
  logic        stall_icache, flush;
  logic [1:0]  out_take;
  logic [1:0]  out_valid;
  logic [63:0] out_pc, out_ir;
  logic        almost_full;
  logic [4:0]  count;
  logic        overflow_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  ent_t mq[$];
  bit   m_af, m_ovf;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH(DEPTH), .IN_W(2), .OUT_W(2), .PC_W(32), .IR_W(32), .AF_MARGIN(AFM)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_pc        (in_pc),
    .in_ir        (in_ir),
    .stall_icache (stall_icache),
    .flush        (flush),
    .out_take     (out_take),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_ir       (out_ir),
    .almost_full  (almost_full),
    .count        (count),
    .overflow_err (overflow_err)
  );

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // One clock: drive inputs, advance the queue model, settle at edge+1.
  task automatic cyc(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                     input logic st, input logic fl, input logic [1:0] tk);
    logic [31:0] i0, i1;
    int nin, nout;
    ent_t e;
    i0 = $urandom;
    i1 = $urandom;
    in_valid = v; in_pc = {p1, p0}; in_ir = {i1, i0};
    stall_icache = st; flush = fl; out_take = tk;
    if (fl) begin
      mq.delete();
      m_af = 1'b0;
    end else begin
      nin  = st ? 0 : $countones(v);
      nout = min2(int'(tk), min2(mq.size(), 2));
      if (mq.size() - nout + nin <= DEPTH) begin
        repeat (nout) void'(mq.pop_front());
        if (nin > 0) begin e.pc = p0; e.ir = i0; mq.push_back(e); end
        if (nin > 1) begin e.pc = p1; e.ir = i1; mq.push_back(e); end
      end else begin
        repeat (nout) void'(mq.pop_front());
        m_ovf = 1'b1;
      end
      m_af = mq.size() >= DEPTH - AFM;
    end
    @(posedge clk);
    #1;
    in_valid = '0; stall_icache = 1'b0; flush = 1'b0; out_take = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = '0; in_pc = '0; in_ir = '0;
    stall_icache = 1'b0; flush = 1'b0; out_take = '0;
    #12;
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL reset_valid got %b want 00", out_valid); end
    n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL reset_af got %b want 0", almost_full); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow_err); end
    rstn = 1'b1;
    mq.delete(); m_af = 1'b0; m_ovf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    cyc(2'b11, 32'h1C00_0000, 32'h1C00_0004, 1'b0, 1'b0, 2'd0);
    n_cmp++; if (out_valid !== 2'b11) begin n_bad++; $display("FAIL basic_valid got %b want 11", out_valid); end
    n_cmp++; if (out_pc[31:0] !== 32'h1C00_0000) begin n_bad++; $display("FAIL basic_pc0 got %h want 1c000000", out_pc[31:0]); end
    n_cmp++; if (out_pc[63:32] !== 32'h1C00_0004) begin n_bad++; $display("FAIL basic_pc1 got %h want 1c000004", out_pc[63:32]); end
    n_cmp++; if (out_ir !== {mq[1].ir, mq[0].ir}) begin n_bad++; $display("FAIL basic_ir got %h want %h", out_ir, {mq[1].ir, mq[0].ir}); end
    n_cmp++; if (count !== 5'd2) begin n_bad++; $display("FAIL basic_count got %0d want 2", count); end
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'd2);
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL basic_drain_count got %0d want 0", count); end
    n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL basic_drain_valid got %b want 00", out_valid); end
  endtask

  task automatic test_partial();
    cyc(2'b11, 32'h0000_1000, 32'h0000_1004, 1'b0, 1'b0, 2'd0);
    cyc(2'b01, 32'h0000_1008, 32'h0, 1'b0, 1'b0, 2'd0);
    n_cmp++; if (count !== 5'd3) begin n_bad++; $display("FAIL partial_load got %0d want 3", count); end
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'd1);
    n_cmp++; if (out_pc[31:0] !== 32'h0000_1004) begin n_bad++; $display("FAIL partial_pc0 got %h want 00001004", out_pc[31:0]); end
    n_cmp++; if (out_pc[63:32] !== 32'h0000_1008) begin n_bad++; $display("FAIL partial_pc1 got %h want 00001008", out_pc[63:32]); end
    n_cmp++; if (count !== 5'd2) begin n_bad++; $display("FAIL partial_count got %0d want 2", count); end
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'd2);
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL partial_empty got %0d want 0", count); end
  endtask

  task automatic test_almost_full();
    for (int k = 0; k < 5; k++) begin
      cyc(2'b11, 32'h0000_2000 + 32'(8*k), 32'h0000_2004 + 32'(8*k), 1'b0, 1'b0, 2'd0);
      if (k == 3) begin
        n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL af_at8 got %b want 0", almost_full); end
      end
    end
    n_cmp++; if (count !== 5'd10) begin n_bad++; $display("FAIL af_count got %0d want 10", count); end
    n_cmp++; if (almost_full !== 1'b1) begin n_bad++; $display("FAIL af_at10 got %b want 1", almost_full); end
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'd1);
    n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL af_at9 got %b want 0", almost_full); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 3; k++) cyc(2'b11, 32'h0000_3000 + 32'(8*k), 32'h0000_3004 + 32'(8*k), 1'b0, 1'b0, 2'd0);
    n_cmp++; if (count !== 5'd15) begin n_bad++; $display("FAIL ovf_fill got %0d want 15", count); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL ovf_before got %b want 0", overflow_err); end
    cyc(2'b11, 32'h0000_4000, 32'h0000_4004, 1'b0, 1'b0, 2'd0);
    n_cmp++; if (count !== 5'd15) begin n_bad++; $display("FAIL ovf_drop_count got %0d want 15", count); end
    n_cmp++; if (overflow_err !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow_err); end
    cyc(2'b01, 32'h0000_4100, 32'h0, 1'b0, 1'b0, 2'd0);
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL ovf_full got %0d want 16", count); end
    cyc(2'b11, 32'h0000_4200, 32'h0000_4204, 1'b0, 1'b0, 2'd2);
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL ovf_full_take got %0d want 16", count); end
    n_cmp++; if (out_pc !== {mq[1].pc, mq[0].pc}) begin n_bad++; $display("FAIL ovf_head got %h want %h", out_pc, {mq[1].pc, mq[0].pc}); end
    n_cmp++; if (overflow_err !== m_ovf) begin n_bad++; $display("FAIL ovf_sticky got %b want %b", overflow_err, m_ovf); end
    // Drain, checking FIFO order against the model.
    while (mq.size() > 0) begin
      n_cmp++; if (out_pc[31:0] !== mq[0].pc) begin n_bad++; $display("FAIL ovf_drain got %h want %h", out_pc[31:0], mq[0].pc); end
      cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'(min2(mq.size(), 2)));
    end
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL ovf_drained got %0d want 0", count); end
  endtask

  task automatic test_wrap();
    logic [31:0] next_pc, exp_pc;
    int tk;
    next_pc = 32'h2000_0000;
    exp_pc  = 32'h2000_0000;
    for (int c = 0; c < 34; c++) begin
      tk = min2(mq.size(), 2);
      for (int i = 0; i < tk; i++) begin
        n_cmp++;
        if (out_pc[i*32 +: 32] !== exp_pc) begin
          n_bad++; $display("FAIL wrap_seq lane %0d got %h want %h", i, out_pc[i*32 +: 32], exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
      end
      n_cmp++; if (count !== 5'(mq.size())) begin n_bad++; $display("FAIL wrap_count got %0d want %0d", count, mq.size()); end
      if (c < 30) begin
        cyc(2'b11, next_pc, next_pc + 32'd4, 1'b0, 1'b0, 2'(tk));
        next_pc = next_pc + 32'd8;
      end else begin
        cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'(tk));
      end
    end
    n_cmp++; if (exp_pc !== next_pc) begin n_bad++; $display("FAIL wrap_total got %h want %h", exp_pc, next_pc); end
  endtask

  task automatic test_flush();
    cyc(2'b11, 32'h0000_5000, 32'h0000_5004, 1'b0, 1'b0, 2'd0);
    cyc(2'b11, 32'h0000_5008, 32'h0000_500C, 1'b0, 1'b0, 2'd0);
    cyc(2'b11, 32'h0000_5010, 32'h0000_5014, 1'b0, 1'b0, 2'd0);
    cyc(2'b01, 32'h0000_5018, 32'h0, 1'b0, 1'b0, 2'd0);
    n_cmp++; if (count !== 5'd7) begin n_bad++; $display("FAIL flush_pre got %0d want 7", count); end
    cyc(2'b11, 32'hDEAD_0000, 32'hDEAD_0004, 1'b0, 1'b1, 2'd2);
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL flush_count got %0d want 0", count); end
    n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL flush_valid got %b want 00", out_valid); end
    n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL flush_af got %b want 0", almost_full); end
    n_cmp++; if (overflow_err !== m_ovf) begin n_bad++; $display("FAIL flush_ovf got %b want %b", overflow_err, m_ovf); end
    cyc(2'b01, 32'h0000_6000, 32'h0, 1'b0, 1'b0, 2'd0);
    n_cmp++; if (out_valid !== 2'b01) begin n_bad++; $display("FAIL flush_after_valid got %b want 01", out_valid); end
    n_cmp++; if (out_pc[31:0] !== 32'h0000_6000) begin n_bad++; $display("FAIL flush_after_pc got %h want 00006000", out_pc[31:0]); end
    cyc(2'b11, 32'h0000_7000, 32'h0000_7004, 1'b1, 1'b0, 2'd0);
    n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL stall_count got %0d want 1", count); end
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'd1);
  endtask

  task automatic test_random();
    logic [1:0] v, tk, ev;
    logic       st, fl;
    int         r;
    for (int c = 0; c < 400; c++) begin
      n_cmp++; if (count !== 5'(mq.size())) begin n_bad++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, count, mq.size()); end
      n_cmp++; if (almost_full !== m_af) begin n_bad++; $display("FAIL rnd_af cyc %0d got %b want %b", c, almost_full, m_af); end
      n_cmp++; if (overflow_err !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf cyc %0d got %b want %b", c, overflow_err, m_ovf); end
      ev = (mq.size() >= 2) ? 2'b11 : ((mq.size() == 1) ? 2'b01 : 2'b00);
      n_cmp++; if (out_valid !== ev) begin n_bad++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, out_valid, ev); end
      for (int i = 0; i < min2(mq.size(), 2); i++) begin
        n_cmp++;
        if (out_pc[i*32 +: 32] !== mq[i].pc || out_ir[i*32 +: 32] !== mq[i].ir) begin
          n_bad++;
          $display("FAIL rnd_lane cyc %0d lane %0d got %h/%h want %h/%h", c, i,
                   out_pc[i*32 +: 32], out_ir[i*32 +: 32], mq[i].pc, mq[i].ir);
        end
      end
      r  = $urandom_range(0, 9);
      v  = (r < 2) ? 2'b00 : ((r < 4) ? 2'b01 : 2'b11);
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 24) == 0);
      tk = 2'($urandom_range(0, min2(mq.size(), 2)));
      cyc(v, $urandom, $urandom, st, fl, tk);
    end
  endtask

  task automatic test_reset_mid();
    cyc(2'b11, 32'h0000_8000, 32'h0000_8004, 1'b0, 1'b0, 2'd0);
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL midrst_count got %0d want 0", count); end
    n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL midrst_valid got %b want 00", out_valid); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL midrst_ovf got %b want 0", overflow_err); end
    n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL midrst_af got %b want 0", almost_full); end
    mq.delete(); m_af = 1'b0; m_ovf = 1'b0;
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
    cyc(2'b01, 32'h0000_9000, 32'h0, 1'b0, 1'b0, 2'd0);
    n_cmp++; if (out_pc[31:0] !== 32'h0000_9000 || count !== 5'd1) begin
      n_bad++; $display("FAIL midrst_after got %h/%0d want 00009000/1", out_pc[31:0], count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_almost_full();
    test_overflow();
    test_wrap();
    test_flush();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
